sort16_readout: RTL and testbench

- Reader side of the top-16 sorter.
- Captures a parallel snapshot of 16 sorted W-bit values, stored ascending with slot 15 as the max.
- Streams the snapshot out serially, largest first, over a valid/ready handshake.
- Each beat carries its rank index, a last flag and a running sum.
- Sits between the sorter register bank and the downstream report/DMA logic.

---
 rtl/sort16_pkg.sv | 17 +
 rtl/sort16_shreg.sv | 38 +++
 rtl/sort16_readout.sv | 124 ++++++++++++
 tb/tb_sort16_readout.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort16_pkg.sv
// Shared types and helpers for the top-16 sorter readout path.
package sort16_pkg;
  localparam int SORT_N  = 16;
  localparam int IDX_W   = 4;
  localparam int SUM_EXT = 4;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  function automatic int sum_w(input int w);
    return w + SUM_EXT;
  endfunction

  // Bit offset of slot k inside the flattened snapshot bus.
  function automatic int slot_lsb(input int w, input int k);
    return k * w;
  endfunction
endpackage

// File: rtl/sort16_shreg.sv
// 16-entry load/shift register; slot 15 is the head, zeros shift in at slot 0.
module sort16_shreg
  import sort16_pkg::*;
#(
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SORT_N*W-1:0] load_data_i,
  input  logic                shift_i,
  output logic [W-1:0]        head_o,
  output logic [W-1:0]        next_o
);
  logic [W-1:0] mem_q [SORT_N];
  logic [W-1:0] mem_d [SORT_N];

  always_comb begin
    for (int k = 0; k < SORT_N; k++) mem_d[k] = mem_q[k];
    if (load_i) begin
      for (int k = 0; k < SORT_N; k++) mem_d[k] = load_data_i[slot_lsb(W, k) +: W];
    end else if (shift_i) begin
      mem_d[0] = '0;
      for (int k = 1; k < SORT_N; k++) mem_d[k] = mem_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SORT_N; k++) mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < SORT_N; k++) mem_q[k] <= mem_d[k];
    end
  end

  assign head_o = mem_q[SORT_N-1];
  assign next_o = mem_q[SORT_N-2];
endmodule

// File: rtl/sort16_readout.sv
// Serial readout of a sorted 16-entry snapshot, largest first, with rank and running sum.
// Optional SORT16_SKIP_ZERO_EN: stop the stream at the first zero (unfilled) entry.
module sort16_readout
  import sort16_pkg::*;
#(
  parameter int W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SnapEn,
  input  logic [SORT_N*W-1:0]   SnapData,
  input  logic                  Abort,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [W-1:0]          OutData,
  output logic [IDX_W-1:0]      OutIdx,
  output logic                  OutLast,
  output logic [sum_w(W)-1:0]   OutSum,
  output logic                  Busy,
  output logic                  Done,
  output logic                  SnapDrop
);
  localparam int SW = sum_w(W);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic [W-1:0] head, nxt, slot15;
  logic         streaming, is_last, snap_empty, load, shift;

  sort16_shreg #(.W(W)) u_shreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .load_data_i (SnapData),
    .shift_i     (shift),
    .head_o      (head),
    .next_o      (nxt)
  );

  always_comb begin
    streaming = (state_q == STREAM);
    slot15    = SnapData[slot_lsb(W, SORT_N-1) +: W];
`ifdef SORT16_SKIP_ZERO_EN
    is_last    = (idx_q == IDX_W'(SORT_N-1)) || (nxt == '0);
    snap_empty = (slot15 == '0);
`else
    is_last    = (idx_q == IDX_W'(SORT_N-1));
    snap_empty = 1'b0;
`endif
    load  = !streaming && SnapEn;
    shift = streaming && OutReady && !Abort;

    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    drop_d  = drop_q;

    if (streaming && SnapEn) drop_d = 1'b1;
    else if (load)           drop_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (SnapEn) begin
          if (snap_empty) begin
            done_d = 1'b1;
          end else begin
            state_d = STREAM;
            idx_d   = '0;
            sum_d   = {{SUM_EXT{1'b0}}, slot15};
          end
        end
      end
      STREAM: begin
        // Abort outranks an accept in the same cycle and suppresses Done.
        if (Abort) begin
          state_d = IDLE;
          idx_d   = '0;
          sum_d   = '0;
        end else if (OutReady) begin
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
            sum_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            sum_d = sum_q + {{SUM_EXT{1'b0}}, nxt};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign OutValid = streaming;
  assign OutData  = streaming ? head : '0;
  assign OutIdx   = idx_q;
  assign OutLast  = streaming && is_last;
  assign OutSum   = sum_q;
  assign Busy     = streaming;
  assign Done     = done_q;
  assign SnapDrop = drop_q;
endmodule

// File: tb/tb_sort16_readout.sv
// Directed bench for sort16_readout with a queue-based reference model and per-cycle compare.
module tb_sort16_readout;
  localparam int W  = 12;
  localparam int N  = 16;
  localparam int SW = W + 4;

  logic            clk = 1'b0;
  logic            rst_n, SnapEn, Abort, OutReady;
  logic [N*W-1:0]  SnapData;
  logic            OutValid, OutLast, Busy, Done, SnapDrop;
  logic [W-1:0]    OutData;
  logic [3:0]      OutIdx;
  logic [SW-1:0]   OutSum;

  int checks = 0;
  int failures = 0;

  // Reference model: the expected stream of one snapshot as a list of beats.
  bit          m_busy, m_done, m_drop;
  int          m_pos;
  int unsigned m_data[$];
  int unsigned m_sum[$];

  // Observed-stream statistics gathered by the compare process.
  int          beats_total = 0;
  int unsigned last_sum = 0, last_idx = 0, first_data = 0;

  always #5 clk = ~clk;

  sort16_readout #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .SnapEn(SnapEn), .SnapData(SnapData), .Abort(Abort),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutIdx(OutIdx),
    .OutLast(OutLast), .OutSum(OutSum), .Busy(Busy), .Done(Done), .SnapDrop(SnapDrop)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_drop = 0; m_pos = 0;
    m_data.delete(); m_sum.delete();
  endtask

  task automatic m_build();
    int unsigned acc = 0;
    int unsigned v;
    m_data.delete(); m_sum.delete();
    for (int r = 0; r < N; r++) begin
      v = SnapData[(N-1-r)*W +: W];
`ifdef SORT16_SKIP_ZERO_EN
      if (v == 0) break;
`endif
      acc += v;
      m_data.push_back(v);
      m_sum.push_back(acc);
    end
  endtask

  task automatic m_step();
    bit nd = 0;
    if (m_busy) begin
      if (SnapEn) m_drop = 1;
      if (Abort) m_busy = 0;
      else if (OutReady) begin
        m_pos++;
        if (m_pos == m_data.size()) begin m_busy = 0; nd = 1; end
      end
    end else if (SnapEn) begin
      m_drop = 0;
      m_build();
      if (m_data.size() == 0) nd = 1;
      else begin m_busy = 1; m_pos = 0; end
    end
    m_done = nd;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid", OutValid, m_busy);
        chk("busy", Busy, m_busy);
        chk("done", Done, m_done);
        chk("snapdrop", SnapDrop, m_drop);
        if (m_busy) begin
          chk("data", OutData, m_data[m_pos]);
          chk("idx", OutIdx, m_pos);
          chk("last", OutLast, (m_pos == m_data.size() - 1));
          chk("sum", OutSum, m_sum[m_pos]);
        end else begin
          chk("last_idle", OutLast, 0);
        end
        if (OutValid && OutReady && !Abort) begin
          beats_total++;
          if (OutIdx == 0) first_data = OutData;
          if (OutLast) begin last_sum = OutSum; last_idx = OutIdx; end
        end
      end
    end
  end

  function automatic logic [N*W-1:0] mk_bus(input int base, input int step);
    logic [N*W-1:0] b;
    for (int k = 0; k < N; k++) b[k*W +: W] = W'(base + step * k);
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic [N*W-1:0] b);
    SnapData = b;
    SnapEn = 1;
    cyc();
    SnapEn = 0;
  endtask

  task automatic drain(input bit toggle);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      OutReady = toggle ? (i % 3 == 0) : 1'b1;
      cyc();
      if (!Busy) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout: got busy expected idle at %0t", $time);
    end
    OutReady = 1;
  endtask

  initial begin
    int b0;
    logic [N*W-1:0] bus;
    rst_n = 1; SnapEn = 0; Abort = 0; OutReady = 0; SnapData = '0;
    #1 rst_n = 0;
    #1;
    chk("rst_valid", OutValid, 0); chk("rst_data", OutData, 0); chk("rst_idx", OutIdx, 0);
    chk("rst_last", OutLast, 0); chk("rst_sum", OutSum, 0); chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0); chk("rst_drop", SnapDrop, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    cyc();

    // Ascending 100..115, full throughput
    b0 = beats_total;
    OutReady = 1;
    snap(mk_bus(100, 1));
    chk("t1_first_data", OutData, 115);
    chk("t1_first_sum", OutSum, 115);
    drain(0);
    chk("t1_done", Done, 1);
    chk("t1_beats", beats_total - b0, 16);
    chk("t1_final_sum", last_sum, 1720);
    chk("t1_last_idx", last_idx, 15);
    chk("t1_first_beat", first_data, 115);
    cyc();
    chk("t1_done_gone", Done, 0);

    // Same snapshot with stalls
    b0 = beats_total;
    snap(mk_bus(100, 1));
    drain(1);
    chk("t2_beats", beats_total - b0, 16);
    chk("t2_final_sum", last_sum, 1720);

    // Saturated values
    b0 = beats_total;
    snap(mk_bus(4095, 0));
    drain(0);
    chk("t3_final_sum", last_sum, 65520);
    chk("t3_beats", beats_total - b0, 16);

    // Abort at rank 5 together with a snapshot request
    OutReady = 1;
    snap(mk_bus(100, 1));
    for (int i = 0; i < 40 && OutIdx != 5; i++) cyc();
    chk("t4_at_idx5", OutIdx, 5);
    Abort = 1; SnapEn = 1;
    cyc();
    Abort = 0; SnapEn = 0;
    chk("t4_valid", OutValid, 0);
    chk("t4_busy", Busy, 0);
    chk("t4_done", Done, 0);
    chk("t4_drop", SnapDrop, 1);
    snap(mk_bus(100, 1));
    chk("t4_restart", OutData, 115);
    chk("t4_drop_clr", SnapDrop, 0);
    drain(0);
    chk("t4_final_sum", last_sum, 1720);

    // SnapEn during stream, then in the Done cycle
    snap(mk_bus(100, 1));
    repeat (3) cyc();
    SnapEn = 1;
    cyc();
    SnapEn = 0;
    chk("t5_drop", SnapDrop, 1);
    for (int i = 0; i < 40 && !Done; i++) cyc();
    chk("t5_done_seen", Done, 1);
    chk("t5_final_sum", last_sum, 1720);
    snap(mk_bus(7, 0));
    chk("t5_accepted", OutValid, 1);
    chk("t5_drop_clr", SnapDrop, 0);
    drain(0);
    chk("t5_sum7", last_sum, 112);

    // Partially filled snapshot: slots 10..15 = 1..6
    bus = '0;
    for (int k = 10; k < N; k++) bus[k*W +: W] = W'(k - 9);
    b0 = beats_total;
    snap(bus);
    drain(0);
    chk("t6_final_sum", last_sum, 21);
`ifdef SORT16_SKIP_ZERO_EN
    chk("t6_beats", beats_total - b0, 6);
    chk("t6_last_idx", last_idx, 5);
`else
    chk("t6_beats", beats_total - b0, 16);
    chk("t6_last_idx", last_idx, 15);
`endif

    // All-zero snapshot
    b0 = beats_total;
    snap('0);
`ifdef SORT16_SKIP_ZERO_EN
    chk("t7_no_valid", OutValid, 0);
    chk("t7_done", Done, 1);
    cyc();
    chk("t7_done_gone", Done, 0);
    chk("t7_beats", beats_total - b0, 0);
`else
    drain(0);
    chk("t7_beats", beats_total - b0, 16);
    chk("t7_sum", last_sum, 0);
`endif

    // Reset mid-stream
    snap(mk_bus(100, 1));
    repeat (2) cyc();
    #2 rst_n = 0;
    #1;
    chk("t8_valid", OutValid, 0); chk("t8_sum", OutSum, 0); chk("t8_idx", OutIdx, 0);
    chk("t8_busy", Busy, 0); chk("t8_done", Done, 0); chk("t8_data", OutData, 0);
    @(negedge clk);
    #2 rst_n = 1;
    repeat (2) cyc();
    chk("t8_idle", OutValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
